// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RISC-V control unit
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALU operation codes, also decoded by the ALU itself
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - ALUOp/funct decode to ALU control plus unsupported-funct flag
module alu_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        funct_illegal = 1'b0;
        alu_control   = ALU_ADD;
        case (funct3)
            3'b000, 3'b110, 3'b111: funct_illegal = 1'b0;
            default:                funct_illegal = 1'b1;
        endcase
        // only R-type uses funct7b5, and only to select SUB
        if (op5 && funct7b5 && (funct3 != 3'b000))
            funct_illegal = 1'b1;

        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RISC-V control FSM driving the datapath enables and ALU selects
module mc_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal_instr,
    output logic       halted
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] alu_op;
    logic       funct_illegal, instr_illegal;
    logic       ir_we, pc_we, reg_we, mem_we;

    alu_dec u_alu_dec (
        .alu_op        (alu_op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .op5           (op[5]),
        .alu_control   (ALUControl),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        instr_illegal = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_JAL: instr_illegal = 1'b0;
            OP_R, OP_I:                   instr_illegal = funct_illegal;
            default:                      instr_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (instr_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECUTER;
                        OP_I:         state_d = S_EXECUTEI;
                        OP_BEQ:       state_d = S_BEQ;
                        default:      state_d = S_JAL;
                    endcase
                end
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op    = ALUOP_ADD;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_we     = 1'b1;
                pc_we     = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_we    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_we = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_we = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                pc_we   = Zero;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pc_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated directly by reset so they drop without waiting for a clock
    assign IRWrite       = ir_we  & reset_n;
    assign PCWrite       = pc_we  & reset_n;
    assign RegWrite      = reg_we & reset_n;
    assign MemWrite      = mem_we & reset_n;
    assign ImmSrc        = imm_src(op);
    assign illegal_instr = illegal_q;
    assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

    logic       clk, reset_n, funct7b5, Zero;
    logic [6:0] op;
    logic [2:0] funct3;

    logic [2:0] alu_c0, alu_c1;
    logic [1:0] srca0, srca1, srcb0, srcb1, res0, res1, imm0, imm1;
    logic       adr0, adr1, ir0, ir1, pc0, pc1, rw0, rw1, mw0, mw1;
    logic       ill0, ill1, halt0, halt1;
    logic [15:0] obs0, obs1;

    int checks = 0;
    int failures = 0;

    mc_controller #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .ALUControl(alu_c0), .ALUSrcA(srca0), .ALUSrcB(srcb0), .ResultSrc(res0), .ImmSrc(imm0),
        .AdrSrc(adr0), .IRWrite(ir0), .PCWrite(pc0), .RegWrite(rw0), .MemWrite(mw0),
        .illegal_instr(ill0), .halted(halt0)
    );

    mc_controller #(.ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .ALUControl(alu_c1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .ResultSrc(res1), .ImmSrc(imm1),
        .AdrSrc(adr1), .IRWrite(ir1), .PCWrite(pc1), .RegWrite(rw1), .MemWrite(mw1),
        .illegal_instr(ill1), .halted(halt1)
    );

    // {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite}
    assign obs0 = {alu_c0, srca0, srcb0, res0, imm0, adr0, ir0, pc0, rw0, mw0};
    assign obs1 = {alu_c1, srca1, srcb1, res1, imm1, adr1, ir1, pc1, rw1, mw1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs0 !== 16'b000_00_10_10_00_0_0_0_0_0) begin
            failures++; $display("FAIL reset_outputs: got %b expected %b", obs0, 16'b000_00_10_10_00_0_0_0_0_0);
        end
        checks++;
        if ({ill0, halt0, ill1, halt1} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b expected 0000", {ill0, halt0, ill1, halt1});
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if ({ir0, pc0, ir1, pc1} !== 4'b1111) begin
            failures++; $display("FAIL reset_release_fetch: got %b expected 1111", {ir0, pc0, ir1, pc1});
        end
    endtask

    task automatic test_lw();
        logic [15:0] e [0:4];
        e = '{16'b000_00_10_10_00_0_1_1_0_0, 16'b000_01_01_00_00_0_0_0_0_0,
              16'b000_10_01_00_00_0_0_0_0_0, 16'b000_00_00_00_00_1_0_0_0_0,
              16'b000_00_00_01_00_0_0_0_1_0};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (obs0 !== e[k]) begin
                failures++; $display("FAIL lw cycle%0d: got %b expected %b", k + 1, obs0, e[k]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (obs0 !== e[0]) begin
            failures++; $display("FAIL lw_return_fetch: got %b expected %b", obs0, e[0]);
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0]  t_op [0:3];
        logic [2:0]  t_f3 [0:3];
        logic        t_f7 [0:3];
        logic [15:0] t_ex [0:3];
        t_op = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
        t_f3 = '{3'b000, 3'b111, 3'b000, 3'b110};
        t_f7 = '{1'b1, 1'b0, 1'b1, 1'b0};
        t_ex = '{16'b001_10_00_00_00_0_0_0_0_0, 16'b010_10_00_00_00_0_0_0_0_0,
                 16'b000_10_01_00_00_0_0_0_0_0, 16'b011_10_01_00_00_0_0_0_0_0};
        for (int v = 0; v < 4; v++) begin
            op = t_op[v]; funct3 = t_f3[v]; funct7b5 = t_f7[v];
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++;
            if (obs0 !== t_ex[v] || obs1 !== t_ex[v]) begin
                failures++; $display("FAIL alu_exec v%0d: got %b/%b expected %b", v, obs0, obs1, t_ex[v]);
            end
            @(posedge clk); #1;
            checks++;
            if (obs0 !== 16'b000_00_00_00_00_0_0_0_1_0) begin
                failures++; $display("FAIL alu_wb v%0d: got %b expected %b", v, obs0, 16'b000_00_00_00_00_0_0_0_1_0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        logic [15:0] e;
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            e = {13'b001_10_00_00_10_0_0, z[0], 2'b00};
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++;
            if (obs0 !== e) begin
                failures++; $display("FAIL beq zero=%0d: got %b expected %b", z, obs0, e);
            end
            @(posedge clk); #1;
            checks++;
            if (obs0 !== 16'b000_00_10_10_10_0_1_1_0_0) begin
                failures++; $display("FAIL beq_cpi zero=%0d: got %b expected fetch", z, obs0);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (obs0 !== 16'b000_01_10_00_11_0_0_1_0_0) begin
            failures++; $display("FAIL jal_state: got %b expected %b", obs0, 16'b000_01_10_00_11_0_0_1_0_0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs0 !== 16'b000_00_00_00_11_0_0_0_1_0) begin
            failures++; $display("FAIL jal_wb: got %b expected %b", obs0, 16'b000_00_00_00_11_0_0_0_1_0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_reset();
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (obs0 !== 16'b000_00_00_00_01_1_0_0_0_1) begin
            failures++; $display("FAIL sw_memwrite: got %b expected %b", obs0, 16'b000_00_00_00_01_1_0_0_0_1);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs0 !== 16'b000_00_10_10_01_0_0_0_0_0 || mw1 !== 1'b0) begin
            failures++; $display("FAIL async_reset_drop: got %b mw1=%b expected %b", obs0, mw1, 16'b000_00_10_10_01_0_0_0_0_0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs0 !== 16'b000_00_10_10_01_0_1_1_0_0) begin
            failures++; $display("FAIL reset_resume_fetch: got %b expected %b", obs0, 16'b000_00_10_10_01_0_1_1_0_0);
        end
    endtask

    task automatic test_illegal_op();
        op = 7'b0110111; funct3 = 3'b000; funct7b5 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs0 !== 16'b000_01_01_00_00_0_0_0_0_0 || ill0 !== 1'b0) begin
            failures++; $display("FAIL illegal_decode: got %b ill=%b expected decode ill=0", obs0, ill0);
        end
        @(posedge clk); #1;
        checks++;
        if (ill0 !== 1'b1 || obs0 !== 16'b000_00_10_10_00_0_1_1_0_0 || halt0 !== 1'b0) begin
            failures++; $display("FAIL illegal_resume: ill=%b obs=%b halted=%b expected 1 fetch 0", ill0, obs0, halt0);
        end
        checks++;
        if (ill1 !== 1'b1 || halt1 !== 1'b1) begin
            failures++; $display("FAIL illegal_enter_halt: ill=%b halted=%b expected 1 1", ill1, halt1);
        end
        @(posedge clk); #1;
        checks++;
        if (ill0 !== 1'b0 || ill1 !== 1'b0) begin
            failures++; $display("FAIL illegal_pulse_width: got %b%b expected 00", ill0, ill1);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (halt1 !== 1'b1 || obs1 !== 16'h0000) begin
                failures++; $display("FAIL halt_hold c%0d: halted=%b obs=%b expected 1 all-zero", k, halt1, obs1);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (halt1 !== 1'b0 || ir1 !== 1'b1) begin
            failures++; $display("FAIL halt_exit_reset: halted=%b irwrite=%b expected 0 1", halt1, ir1);
        end
    endtask

    task automatic test_illegal_funct();
        logic [2:0] t_f3 [0:1];
        logic       t_f7 [0:1];
        t_f3 = '{3'b001, 3'b111};
        t_f7 = '{1'b0, 1'b1};
        op = 7'b0110011;
        for (int v = 0; v < 2; v++) begin
            funct3 = t_f3[v]; funct7b5 = t_f7[v];
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++;
            if (ill0 !== 1'b1 || obs0 !== 16'b000_00_10_10_00_0_1_1_0_0) begin
                failures++; $display("FAIL illegal_funct v%0d: ill=%b obs=%b expected 1 fetch", v, ill0, obs0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_alu_ops();
        test_beq();
        test_jal();
        test_sw_reset();
        test_illegal_op();
        test_illegal_funct();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
